// File: rtl/pc_control_unit_pkg.sv
// Shared types and constants for the PC control unit.
// Holds the FSM state encoding, next-PC select encoding and PC step size.
// No ports; imported by the interface, the select mux and the top.
package pc_control_unit_pkg;

  // Two-state control FSM: fetch advances in RUN, is frozen in HALT.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // Source of the next PC when the PC register is loaded.
  typedef enum logic {
    SEL_SEQ = 1'b0,  // pc + PC_STEP
    SEL_TGT = 1'b1   // word-aligned jump/branch target
  } sel_t;

  // Instructions are one word wide.
  localparam int PC_STEP = 4;

  // A redirect target is misaligned when either of its byte-offset bits is set.
  function automatic logic is_misaligned(input logic [1:0] lo);
    return |lo;
  endfunction

endpackage

// File: rtl/pc_control_unit_if.sv
// Control/status bundle between the pipeline front end and the PC control unit.
// master: drives stall/jmp_en/br_en/br_cond/target/halt/resume, observes PC state.
// slave:  the PC control unit; drives pc/pc_plus4/redirect/misalign/halted/retire_cnt.
interface pc_control_unit_if #(
  parameter int ADDR_W = 32
) ();

  // Control requests, sampled on the rising clock edge.
  logic              stall;
  logic              jmp_en;
  logic              br_en;
  logic              br_cond;
  logic [ADDR_W-1:0] target;
  logic              halt;
  logic              resume;

  // PC state and status.
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              redirect;
  logic              misalign;
  logic              halted;
  logic [31:0]       retire_cnt;

  modport master (
    output stall, jmp_en, br_en, br_cond, target, halt, resume,
    input  pc, pc_plus4, redirect, misalign, halted, retire_cnt
  );

  modport slave (
    input  stall, jmp_en, br_en, br_cond, target, halt, resume,
    output pc, pc_plus4, redirect, misalign, halted, retire_cnt
  );

endinterface

// File: rtl/pc_control_unit_next_pc_sel.sv
// Next-PC mux: chooses the sequential PC or the word-aligned redirect target.
// Latency: purely combinational. Backpressure: none (hold is handled by the caller).
// Ports: pc_plus4, target, select in; next_pc out.
module next_pc_sel
  import pc_control_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [ADDR_W-1:0] target,
  input  sel_t              select,
  output logic [ADDR_W-1:0] next_pc
);

  // Clears the byte-offset bits so redirects always land on a word boundary.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  always_comb begin
    next_pc = pc_plus4;
    if (select == SEL_TGT) begin
      next_pc = target & WORD_MASK;
    end
  end

endmodule

// File: rtl/pc_control_unit.sv
// Program-counter control: sequential fetch, jumps, taken branches, stall and halt/resume.
// Latency: controls sampled at edge N show on pc after edge N; redirect pulses the cycle after.
// Backpressure: stall freezes pc/retire_cnt for a cycle; HALT freezes everything until resume.
// Ports: clk, rst (sync, active high), bus (pc_control_unit_if.slave).
module pc_control_unit
  import pc_control_unit_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  pc_control_unit_if.slave   bus
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect_q;
  logic              misalign_q;
  logic [31:0]       retire_q;

  // Decoded per-cycle actions.
  logic              load_pc;   // pc register takes next_pc this edge
  logic              take;      // the load comes from the target (jump or taken branch)
  sel_t              select;

  assign pc_plus4 = pc_q + ADDR_W'(PC_STEP);

  // Next-state and action decode. In RUN the priority is
  // halt > stall > jump > taken branch > sequential; HALT only listens to resume.
  always_comb begin
    state_d = state_q;
    load_pc = 1'b0;
    take    = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.halt) begin
          state_d = HALT;
        end else if (!bus.stall) begin
          load_pc = 1'b1;
          take    = bus.jmp_en | (bus.br_en & bus.br_cond);
        end
      end
      HALT: begin
        // The first advance after resume happens one cycle later, from RUN.
        if (bus.resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign select = take ? SEL_TGT : SEL_SEQ;

  next_pc_sel #(
    .ADDR_W (ADDR_W)
  ) u_next_pc_sel (
    .pc_plus4 (pc_plus4),
    .target   (bus.target),
    .select   (select),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= load_pc & take;
      if (load_pc) begin
        pc_q     <= next_pc;
        retire_q <= retire_q + 32'd1;
      end
      // Sticky until reset: software reads it as "some redirect was bad".
      if (load_pc && take && is_misaligned(bus.target[1:0])) begin
        misalign_q <= 1'b1;
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.redirect   = redirect_q;
  assign bus.misalign   = misalign_q;
  assign bus.halted     = (state_q == HALT);
  assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Scoreboard bench for pc_control_unit: two instances (reset PC 0 and 0xFFFF_FFF8)
// share the same stimulus; a reference model pushes expected state per edge and a
// monitor pops and compares after every rising edge.
module tb_pc_control_unit;
  import pc_control_unit_pkg::*;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_control_unit_if #(.ADDR_W(32)) bus_a ();
  pc_control_unit_if #(.ADDR_W(32)) bus_b ();

  pc_control_unit #(.ADDR_W(32), .RESET_PC(RST_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pc_control_unit #(.ADDR_W(32), .RESET_PC(RST_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        red;
    logic        mis;
    logic        hlt;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance.
  logic [31:0] m_pc  [2];
  logic [31:0] m_cnt [2];
  logic        m_red [2];
  logic        m_mis [2];
  logic        m_hlt [2];

  // Architectural behaviour of one clock edge, written from the rules directly.
  task automatic model_edge(input int i, input logic r, input logic st, input logic j,
                            input logic be, input logic bc, input logic h,
                            input logic res, input logic [31:0] tgt);
    if (r) begin
      m_pc[i]  = (i == 0) ? RST_A : RST_B;
      m_cnt[i] = 0;
      m_red[i] = 0;
      m_mis[i] = 0;
      m_hlt[i] = 0;
    end else if (m_hlt[i]) begin
      m_red[i] = 0;
      if (res) m_hlt[i] = 0;
    end else if (h) begin
      m_hlt[i] = 1;
      m_red[i] = 0;
    end else if (st) begin
      m_red[i] = 0;
    end else if (j || (be && bc)) begin
      m_pc[i]  = {tgt[31:2], 2'b00};
      m_red[i] = 1;
      m_cnt[i] = m_cnt[i] + 1;
      if (tgt[1:0] != 2'b00) m_mis[i] = 1;
    end else begin
      m_pc[i]  = m_pc[i] + 32'd4;
      m_red[i] = 0;
      m_cnt[i] = m_cnt[i] + 1;
    end
  endtask

  // Drive one cycle of stimulus on both instances and record what must follow.
  task automatic step(input logic r, input logic st, input logic j, input logic be,
                      input logic bc, input logic h, input logic res,
                      input logic [31:0] tgt);
    exp_t e;
    @(negedge clk);
    rst           = r;
    bus_a.stall   = st;  bus_b.stall   = st;
    bus_a.jmp_en  = j;   bus_b.jmp_en  = j;
    bus_a.br_en   = be;  bus_b.br_en   = be;
    bus_a.br_cond = bc;  bus_b.br_cond = bc;
    bus_a.halt    = h;   bus_b.halt    = h;
    bus_a.resume  = res; bus_b.resume  = res;
    bus_a.target  = tgt; bus_b.target  = tgt;
    for (int i = 0; i < 2; i++) begin
      model_edge(i, r, st, j, be, bc, h, res, tgt);
      e.pc  = m_pc[i];
      e.cnt = m_cnt[i];
      e.red = m_red[i];
      e.mis = m_mis[i];
      e.hlt = m_hlt[i];
      if (i == 0) exp_a.push_back(e);
      else        exp_b.push_back(e);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic jump(input logic [31:0] tgt);
    step(0, 0, 1, 0, 0, 0, 0, tgt);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising edge produces a new observable state.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      check("a.pc",         bus_a.pc,                 e.pc);
      check("a.pc_plus4",   bus_a.pc_plus4,           e.pc + 32'd4);
      check("a.retire_cnt", bus_a.retire_cnt,         e.cnt);
      check("a.redirect",   {31'd0, bus_a.redirect},  {31'd0, e.red});
      check("a.misalign",   {31'd0, bus_a.misalign},  {31'd0, e.mis});
      check("a.halted",     {31'd0, bus_a.halted},    {31'd0, e.hlt});
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      check("b.pc",         bus_b.pc,                 e.pc);
      check("b.pc_plus4",   bus_b.pc_plus4,           e.pc + 32'd4);
      check("b.retire_cnt", bus_b.retire_cnt,         e.cnt);
      check("b.redirect",   {31'd0, bus_b.redirect},  {31'd0, e.red});
      check("b.misalign",   {31'd0, bus_b.misalign},  {31'd0, e.mis});
      check("b.halted",     {31'd0, bus_b.halted},    {31'd0, e.hlt});
    end
  end

  initial begin
    logic [31:0] t;
    int drain;

    // Reset, then three sequential advances: 0x0 -> 0x4 -> 0x8 -> 0xC.
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    repeat (3) idle();
    idle();                              // pc = 0x10

    // Jump, then a not-taken branch.
    jump(32'h100);
    step(0, 0, 0, 1, 0, 0, 0, 32'h999);  // pc = 0x104

    // Stall beats jump; the jump lands once the stall drops.
    jump(32'h20);
    step(0, 1, 1, 0, 0, 0, 0, 32'h80);
    jump(32'h80);

    // Misaligned taken branch sets the sticky flag; later jumps keep it.
    step(0, 0, 0, 1, 1, 0, 0, 32'h203);
    jump(32'h300);
    idle();

    // Halt beats jump; HALT ignores everything but resume.
    jump(32'h40);
    step(0, 0, 1, 0, 0, 1, 0, 32'h500);
    for (int k = 0; k < 5; k++) step(0, k[0], 1, 1, 1, 1, 0, 32'h601);
    step(0, 0, 1, 0, 0, 0, 1, 32'h700); // resume: pc unchanged, jump ignored
    idle();                              // pc = 0x44
    step(0, 0, 0, 0, 0, 0, 1, 32'h0);    // resume in RUN is a plain advance

    // Reset mid-jump and mid-stall.
    step(1, 0, 1, 0, 0, 0, 0, 32'h1234);
    step(1, 1, 0, 0, 0, 0, 0, 32'h0);

    // Wrap on the second instance (0xFFFF_FFF8 -> FFFC -> 0), then reset while halted.
    idle();
    idle();
    step(0, 0, 0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 1, 0, 0, 0, 0, 32'h88);
    step(1, 0, 0, 0, 0, 1, 0, 32'h0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      t = $urandom();
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 2) == 0),
           t);
    end

    drain = 0;
    while ((exp_a.size() > 0 || exp_b.size() > 0) && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    #2;
    checks++;
    if (exp_a.size() > 0 || exp_b.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0", exp_a.size(), exp_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_control_unit.md
PC_CONTROL_UNIT -- requirements
Module: pc_control_unit

Interface
REQ-001 Parameter: ADDR_W, default 32, program-counter width in bits.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port: stall  input  1  hold the PC for this cycle.
REQ-006 Port: jmp_en  input  1  unconditional jump to target this cycle.
REQ-007 Port: br_en  input  1  current instruction is a conditional branch.
REQ-008 Port: br_cond  input  1  branch condition result; taken when br_en && br_cond.
REQ-009 Port: target  input  ADDR_W  jump/branch destination address.
REQ-010 Port: halt  input  1  request to enter HALT state.
REQ-011 Port: resume  input  1  request to leave HALT state.
REQ-012 Port: pc  output  ADDR_W  current program counter (registered).
REQ-013 Port: pc_plus4  output  ADDR_W  pc + 4 (combinational, modulo 2^ADDR_W).
REQ-014 Port: redirect  output  1  registered pulse: the previous edge loaded pc from target.
REQ-015 Port: misalign  output  1  sticky flag: a taken target had nonzero bits [1:0].
REQ-016 Port: halted  output  1  high while the FSM is in HALT.
REQ-017 Port: retire_cnt  output  32  count of cycles in which pc advanced or redirected.

Function
REQ-018 The FSM SHALL have two states, RUN and HALT; RUN is the reset state.
REQ-019 In RUN, the next-PC priority SHALL be: halt > stall > jmp_en > (br_en && br_cond) > sequential (pc + 4).
REQ-020 In RUN with halt=1, the FSM SHALL go to HALT and pc SHALL hold, regardless of jmp_en/branch.
REQ-021 In RUN with stall=1 (halt=0), pc, retire_cnt and state SHALL hold, and redirect SHALL be 0 next cycle.
REQ-022 On jump or taken branch, pc SHALL load {target[ADDR_W-1:2], 2'b00} and redirect SHALL be 1 in the following cycle only.
REQ-023 If a taken target has target[1:0] != 0, misalign SHALL set on that edge and stay set until reset.
REQ-024 br_en=1 with br_cond=0 SHALL behave as sequential (pc + 4, redirect 0).
REQ-025 The sequential increment SHALL wrap: pc = 2^ADDR_W - 4 advances to 0.
REQ-026 In HALT, pc, retire_cnt and misalign SHALL hold; jmp_en, br_en, stall and halt SHALL be ignored.
REQ-027 In HALT with resume=1, the FSM SHALL return to RUN on the next edge with pc unchanged; the first advance occurs one cycle later.
REQ-028 resume in RUN SHALL have no effect.
REQ-029 retire_cnt SHALL increment by 1 on every edge where pc is loaded (sequential or redirect) and SHALL wrap at 2^32.
REQ-030 halted SHALL be a decode of the registered state (no combinational path from halt).
REQ-031 Latency: a control input sampled at edge N SHALL be reflected on pc after edge N.

Reset
REQ-032 With rst=1 at a rising edge: pc = RESET_PC, state = RUN, redirect = 0, misalign = 0, retire_cnt = 0, halted = 0.
REQ-033 rst SHALL override all other inputs, including mid-jump, stalled, and HALT conditions.
REQ-034 pc_plus4 SHALL equal RESET_PC + 4 in the cycle after reset.

Structure
REQ-035 A shared package SHALL hold the state encodings (RUN=1'b0, HALT=1'b1) and the PC_STEP constant (4).
REQ-036 Next-PC selection SHALL be a combinational sub-module named next_pc_sel (inputs pc_plus4, target, select; output next_pc).
REQ-037 pc_control_unit SHALL contain all registers and the FSM.

Verification
REQ-038 Reset, then 3 idle cycles -> pc = 0x0, 0x4, 0x8, 0xC; retire_cnt = 3; redirect = 0.
REQ-039 At pc = 0x10: jmp_en=1, target=0x100 -> pc = 0x100, redirect = 1 for one cycle. Then br_en=1, br_cond=0 -> pc = 0x104.
REQ-040 stall=1 and jmp_en=1 at pc = 0x20 -> pc stays 0x20. Next cycle, stall=0 with jmp_en=1 -> pc = target.
REQ-041 Branch taken with target=0x203 -> pc = 0x200, misalign = 1. misalign remains 1 after further jumps and clears only on rst.
REQ-042 halt=1 together with jmp_en=1 at pc = 0x40 -> halted = 1 and pc = 0x40 for 5 cycles despite jmp_en. Then resume=1 -> halted = 0 with pc = 0x40, and the next cycle pc = 0x44.
REQ-043 Wrap and reset mid-operation: with RESET_PC = 0xFFFF_FFF8, two advances -> pc = 0xFFFF_FFFC, then 0x0. Asserting rst while halted -> pc = 0xFFFF_FFF8, halted = 0, retire_cnt = 0.
